// File: rtl/rr_arb_n.sv
// rr_arb_n: N-channel round-robin arbiter with grant hold,
// hold-time limit and starvation masking.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   req      per-channel request
//   ack      registered one-hot grant (zero when idle)
//   ack_vld  registered, equals |ack
//   ack_id   registered index of the granted channel (0 when idle)
//   expire   one-cycle pulse: holder forced off by the MAXHOLD limit
module rr_arb_n #(
   parameter int N       = 4,
   parameter int MAXHOLD = 16,
   parameter int IDXW    = $clog2(N),
   parameter int CNTW    = (MAXHOLD == 0) ? 1 : $clog2(MAXHOLD + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    ack,
   output logic            ack_vld,
   output logic [IDXW-1:0] ack_id,
   output logic            expire
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
   localparam logic [CNTW-1:0] HMAX = CNTW'(MAXHOLD);

   state_t            r_state;
   logic [IDXW-1:0]   r_pri;
   logic [IDXW-1:0]   r_holder;
   logic [CNTW-1:0]   r_hcnt;
   logic [N-1:0]      r_mask;
   logic [N-1:0]      r_ack;
   logic              r_vld;
   logic [IDXW-1:0]   r_ack_id;
   logic              r_expire;

   state_t            w_state;
   logic [IDXW-1:0]   w_pri;
   logic [IDXW-1:0]   w_holder;
   logic [CNTW-1:0]   w_hcnt;
   logic [N-1:0]      w_mask;
   logic [N-1:0]      w_ack;
   logic              w_vld;
   logic [IDXW-1:0]   w_ack_id;
   logic              w_expire;

   logic [N-1:0]      w_elig;
   logic [IDXW-1:0]   w_pick;
   logic              w_found;
   logic [IDXW-1:0]   w_nxt_pri;
   logic              w_rel;
   logic              w_lim;

   // Circular first-set scan starting at the priority pointer.
   // Indices wrap at N, so pick never reaches N for odd widths.
   function automatic logic [IDXW:0] f_pick(
      input logic [N-1:0]    e,
      input logic [IDXW-1:0] p
   );
      logic [IDXW:0] res;
      int            j;
      res = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(p) + i;
         if (j >= N)
            j = j - N;
         if (!res[IDXW] && e[j]) begin
            res = {1'b1, IDXW'(j)};
         end
      end
      return res;
   endfunction

   assign w_elig = req & ~r_mask;
   assign {w_found, w_pick} = f_pick(w_elig, r_pri);

   assign w_nxt_pri = (r_holder == LAST) ? '0
                    : r_holder + 1'b1;
   assign w_rel = ~req[r_holder];
   assign w_lim = (MAXHOLD != 0) && (r_hcnt == HMAX);

   always_comb begin
      w_state  = r_state;
      w_pri    = r_pri;
      w_holder = r_holder;
      w_hcnt   = r_hcnt;
      w_ack    = r_ack;
      w_vld    = r_vld;
      w_ack_id = r_ack_id;
      w_expire = 1'b0;
      // Mask bits clear once their request is seen low;
      // a set on the same edge wins via the OR below.
      w_mask   = r_mask & req;
      unique case (r_state)
         IDLE: begin
            w_ack    = '0;
            w_vld    = 1'b0;
            w_ack_id = '0;
            if (w_found) begin
               w_state  = GRANT;
               w_holder = w_pick;
               w_ack    = N'(1) << w_pick;
               w_vld    = 1'b1;
               w_ack_id = w_pick;
               if (MAXHOLD != 0)
                  w_hcnt = CNTW'(1);
            end
         end
         GRANT: begin
            if (w_rel) begin
               w_state  = IDLE;
               w_pri    = w_nxt_pri;
               w_ack    = '0;
               w_vld    = 1'b0;
               w_ack_id = '0;
            end else if (w_lim) begin
               w_state  = IDLE;
               w_pri    = w_nxt_pri;
               w_ack    = '0;
               w_vld    = 1'b0;
               w_ack_id = '0;
               w_expire = 1'b1;
               w_mask   = w_mask
                        | (N'(1) << r_holder);
            end else if (MAXHOLD != 0) begin
               if (r_hcnt != HMAX)
                  w_hcnt = r_hcnt + 1'b1;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_pri    <= '0;
         r_holder <= '0;
         r_hcnt   <= '0;
         r_mask   <= '0;
         r_ack    <= '0;
         r_vld    <= 1'b0;
         r_ack_id <= '0;
         r_expire <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_pri    <= w_pri;
         r_holder <= w_holder;
         r_hcnt   <= w_hcnt;
         r_mask   <= w_mask;
         r_ack    <= w_ack;
         r_vld    <= w_vld;
         r_ack_id <= w_ack_id;
         r_expire <= w_expire;
      end
   end

   assign ack     = r_ack;
   assign ack_vld = r_vld;
   assign ack_id  = r_ack_id;
   assign expire  = r_expire;

endmodule
